// File: rtl/ip_sched_pkg.sv
// Shared types and constants for the ip_forward inner-product sequencer.
package ip_sched_pkg;

   localparam int ID_VALID_BIT = 7;
   localparam int SEQ_W        = 7;
   localparam int META_ROW_W   = 10;
   localparam int META_TILE_W  = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FIN
   } sched_state_t;

   typedef struct packed {
      logic [META_ROW_W-1:0]  row;
      logic [META_TILE_W-1:0] tile;
      logic                   last;
      logic [SEQ_W-1:0]       seq;
   } meta_t;

   // The sequence tag has served its purpose once a result is matched, so it is not buffered.
   typedef struct packed {
      logic [31:0]            data;
      logic [META_ROW_W-1:0]  row;
      logic [META_TILE_W-1:0] tile;
      logic                   last;
   } result_t;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous FIFO with occupancy count; a pop frees space for a same-cycle push when full.
module sched_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (do_push && !do_pop) begin
            count <= count + CW'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/ip_forward_sched.sv
// Sequencer for the ip_forward datapath: walks rows x tiles, tags issued tiles,
// reorders nothing (datapath is in-order) and buffers results behind a credit limit.
module ip_forward_sched
   import ip_sched_pkg::*;
#(
   parameter int ROW_W        = 10,
   parameter int TILE_W       = 8,
   parameter int PIPE_LAT     = 16,
   parameter int RESULT_DEPTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ROW_W-1:0]        cfg_rows,
   input  logic [TILE_W-1:0]       cfg_tiles,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [TILE_W-1:0]       in_addr,
   output logic [ROW_W+TILE_W-1:0] w_addr,
   output logic [7:0]              dp_in_id,
   input  logic [7:0]              dp_out_id,
   input  logic [31:0]             dp_out_data,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [31:0]             res_data,
   output logic [ROW_W-1:0]        res_row,
   output logic [TILE_W-1:0]       res_tile,
   output logic                    res_last
);

   localparam int AW         = ROW_W + TILE_W;
   localparam int META_DEPTH = PIPE_LAT + 2;
   localparam int MCW        = $clog2(META_DEPTH + 1);
   localparam int RCW        = $clog2(RESULT_DEPTH + 1);

   generate
      if (RESULT_DEPTH < PIPE_LAT + 2) begin : g_depth_chk
         $error("ip_forward_sched: RESULT_DEPTH must be at least PIPE_LAT+2");
      end
      if (ROW_W != META_ROW_W || TILE_W != META_TILE_W) begin : g_width_chk
         $error("ip_forward_sched: ROW_W/TILE_W must match the metadata struct widths");
      end
   endgenerate

   sched_state_t     state;
   sched_state_t     state_nxt;
   logic [ROW_W-1:0]  rows_q;
   logic [ROW_W-1:0]  row_q;
   logic [TILE_W-1:0] tiles_q;
   logic [TILE_W-1:0] tile_q;
   logic [AW-1:0]     base_q;
   logic [SEQ_W-1:0]  seq_q;
   logic [RCW-1:0]    inflight_q;
   logic              err_q;
   logic              done_q;
   logic [7:0]        dp_in_id_q;

   logic    start_ok;
   logic    issue;
   logic    credit_ok;
   logic    tile_last;
   logic    row_last;
   logic    ret_valid;
   logic    ret_err;
   logic    overflow;
   logic    meta_pop;
   logic    res_push;
   logic    res_pop;
   meta_t   meta_in;
   meta_t   meta_head;
   result_t res_in;
   result_t res_head;
   logic    meta_empty;
   logic    meta_full;
   logic    res_empty;
   logic    res_full;
   logic [MCW-1:0] meta_count;
   logic [RCW-1:0] res_count;

   assign start_ok  = (state == IDLE) && start;
   assign tile_last = (tile_q == tiles_q - TILE_W'(1));
   assign row_last  = (row_q == rows_q - ROW_W'(1));
   // Every issued tile must already own a result-buffer slot, since the datapath cannot stall.
   assign credit_ok = (32'(inflight_q) + 32'(res_count) + 32'd1) <= 32'(RESULT_DEPTH);

   assign ret_valid = dp_out_id[ID_VALID_BIT];
   assign meta_pop  = ret_valid && !meta_empty;
   assign ret_err   = ret_valid && (meta_empty || (dp_out_id[SEQ_W-1:0] != meta_head.seq));
   assign res_push  = meta_pop;
   assign res_pop   = res_valid && res_ready;
   assign overflow  = (res_push && res_full && !res_pop) || (issue && meta_full && !meta_pop);

   always_comb begin
      meta_in.row  = row_q;
      meta_in.tile = tile_q;
      meta_in.last = tile_last;
      meta_in.seq  = seq_q;
      res_in.data  = dp_out_data;
      res_in.row   = meta_head.row;
      res_in.tile  = meta_head.tile;
      res_in.last  = meta_head.last;
   end

   // Next state and the per-cycle issue decision.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (cfg_rows == '0 || cfg_tiles == '0) ? FIN : ISSUE;
            end
         end
         ISSUE: begin
            if (credit_ok) begin
               issue = 1'b1;
               if (row_last && tile_last) begin
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (inflight_q == '0 && res_empty && meta_count == '0) begin
               state_nxt = FIN;
            end
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Walk counters, running weight base (replaces row*cfg_tiles), tags, credit and flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rows_q     <= '0;
         tiles_q    <= '0;
         row_q      <= '0;
         tile_q     <= '0;
         base_q     <= '0;
         seq_q      <= '0;
         inflight_q <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         dp_in_id_q <= '0;
      end else begin
         dp_in_id_q <= issue ? {1'b1, seq_q} : 8'h00;
         done_q     <= (state == FIN);

         if (start_ok) begin
            rows_q  <= cfg_rows;
            tiles_q <= cfg_tiles;
            row_q   <= '0;
            tile_q  <= '0;
            base_q  <= '0;
            seq_q   <= '0;
         end else if (issue) begin
            seq_q <= seq_q + SEQ_W'(1);
            if (tile_last) begin
               tile_q <= '0;
               row_q  <= row_q + ROW_W'(1);
               base_q <= base_q + AW'(tiles_q);
            end else begin
               tile_q <= tile_q + TILE_W'(1);
            end
         end

         if (issue && !ret_valid) begin
            inflight_q <= inflight_q + RCW'(1);
         end else if (!issue && ret_valid && inflight_q != '0) begin
            inflight_q <= inflight_q - RCW'(1);
         end

         if (start_ok) begin
            err_q <= 1'b0;
         end else if (ret_err || overflow) begin
            err_q <= 1'b1;
         end
      end
   end

   sched_fifo #(
      .WIDTH ($bits(meta_t)),
      .DEPTH (META_DEPTH)
   ) u_meta_q (
      .clk   (clk),
      .reset (reset),
      .push  (issue),
      .din   (meta_in),
      .pop   (meta_pop),
      .dout  (meta_head),
      .empty (meta_empty),
      .full  (meta_full),
      .count (meta_count)
   );

   sched_fifo #(
      .WIDTH ($bits(result_t)),
      .DEPTH (RESULT_DEPTH)
   ) u_res_buf (
      .clk   (clk),
      .reset (reset),
      .push  (res_push),
      .din   (res_in),
      .pop   (res_pop),
      .dout  (res_head),
      .empty (res_empty),
      .full  (res_full),
      .count (res_count)
   );

   assign busy      = (state == ISSUE) || (state == DRAIN);
   assign done      = done_q;
   assign err       = err_q;
   assign in_addr   = tile_q;
   assign w_addr    = base_q + AW'(tile_q);
   assign dp_in_id  = dp_in_id_q;
   assign res_valid = !res_empty;
   assign res_data  = res_head.data;
   assign res_row   = res_head.row;
   assign res_tile  = res_head.tile;
   assign res_last  = res_head.last;

endmodule

// File: tb/tb_ip_forward_sched.sv
// Scoreboard bench for ip_forward_sched with a fixed-latency datapath and memory model.
module tb_ip_forward_sched;

   localparam int ROW_W        = 10;
   localparam int TILE_W       = 8;
   localparam int PIPE_LAT     = 16;
   localparam int RESULT_DEPTH = 32;
   localparam int AW           = ROW_W + TILE_W;

   logic              clk       = 1'b0;
   logic              reset     = 1'b0;
   logic              start     = 1'b0;
   logic              res_ready = 1'b0;
   logic [ROW_W-1:0]  cfg_rows  = '0;
   logic [TILE_W-1:0] cfg_tiles = '0;
   logic              busy;
   logic              done;
   logic              err;
   logic [TILE_W-1:0] in_addr;
   logic [AW-1:0]     w_addr;
   logic [7:0]        dp_in_id;
   logic [7:0]        dp_out_id;
   logic [31:0]       dp_out_data;
   logic              res_valid;
   logic [31:0]       res_data;
   logic [ROW_W-1:0]  res_row;
   logic [TILE_W-1:0] res_tile;
   logic              res_last;

   ip_forward_sched #(
      .ROW_W        (ROW_W),
      .TILE_W       (TILE_W),
      .PIPE_LAT     (PIPE_LAT),
      .RESULT_DEPTH (RESULT_DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .cfg_rows    (cfg_rows),
      .cfg_tiles   (cfg_tiles),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .in_addr     (in_addr),
      .w_addr      (w_addr),
      .dp_in_id    (dp_in_id),
      .dp_out_id   (dp_out_id),
      .dp_out_data (dp_out_data),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_row     (res_row),
      .res_tile    (res_tile),
      .res_last    (res_last)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int issue_cnt   = 0;
   int done_cnt    = 0;
   int valid_cnt   = 0;
   int ready_mode  = 1;
   logic [5:0] salt        = '0;
   logic       corrupt_tag = 1'b0;
   logic [50:0] exp_q [$];

   // Memory word seen by the datapath: encodes both read addresses so address errors show up in data.
   function automatic logic [31:0] memWord(input logic [5:0] s, input logic [TILE_W-1:0] ia,
                                           input logic [AW-1:0] wa);
      return {s, wa, ia};
   endfunction

   // Memory (1-cycle read) feeding a PIPE_LAT-deep non-stalling datapath; optionally corrupts tag 2.
   logic [7:0]        stage_id   [PIPE_LAT];
   logic [31:0]       stage_data [PIPE_LAT];
   logic [TILE_W-1:0] mem_in_addr;
   logic [AW-1:0]     mem_w_addr;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            stage_id[i]   <= '0;
            stage_data[i] <= '0;
         end
         mem_in_addr <= '0;
         mem_w_addr  <= '0;
      end else begin
         mem_in_addr   <= in_addr;
         mem_w_addr    <= w_addr;
         stage_id[0]   <= (corrupt_tag && dp_in_id == 8'h82) ? 8'h83 : dp_in_id;
         stage_data[0] <= memWord(salt, mem_in_addr, mem_w_addr);
         for (int i = 1; i < PIPE_LAT; i++) begin
            stage_id[i]   <= stage_id[i-1];
            stage_data[i] <= stage_data[i-1];
         end
      end
   end

   assign dp_out_id   = stage_id[PIPE_LAT-1];
   assign dp_out_data = stage_data[PIPE_LAT-1];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Downstream ready: 0 = held low, 1 = held high, otherwise random per cycle.
   initial begin : ready_driver
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            default: res_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pops the scoreboard on each accepted result and checks that stalled outputs hold.
   initial begin : monitor
      logic [50:0] cur;
      logic [50:0] held;
      logic        hold;
      hold = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         cur = {res_data, res_row, res_tile, res_last};
         if (!reset) begin
            hold = 1'b0;
         end else begin
            if (hold) checkOutput("stable_while_stalled", 64'(cur), 64'(held));
            if (dp_in_id[7]) issue_cnt++;
            if (done) done_cnt++;
            if (res_valid) valid_cnt++;
            if (res_valid && res_ready) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result", cur);
               end else begin
                  checkOutput("result", 64'(cur), 64'(exp_q.pop_front()));
               end
               hold = 1'b0;
            end else begin
               hold = res_valid;
               held = cur;
            end
         end
      end
   end

   int job_i0;
   int job_d0;
   int job_v0;
   int job_n;

   task automatic applyStimulus(input int rows, input int tiles);
      @(posedge clk);
      #1;
      cfg_rows  = ROW_W'(rows);
      cfg_tiles = TILE_W'(tiles);
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Reference: results come back row-major with addresses row*tiles+tile and tile.
   task automatic beginJob(input int rows, input int tiles, input int mode);
      salt       = 6'($urandom);
      ready_mode = mode;
      for (int r = 0; r < rows; r++) begin
         for (int t = 0; t < tiles; t++) begin
            exp_q.push_back({memWord(salt, TILE_W'(t), AW'(r * tiles + t)),
                             ROW_W'(r), TILE_W'(t), (t == tiles - 1)});
         end
      end
      job_i0 = issue_cnt;
      job_d0 = done_cnt;
      job_v0 = valid_cnt;
      job_n  = rows * tiles;
      applyStimulus(rows, tiles);
   endtask

   task automatic endJob(input logic exp_err, input int bound);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < bound && !seen; n++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL done_timeout: done not seen within %0d cycles", bound);
      end
      @(negedge clk);
      @(negedge clk);
      checkOutput("issue_count", 64'(issue_cnt - job_i0), 64'(job_n));
      checkOutput("done_pulses", 64'(done_cnt - job_d0), 64'd1);
      checkOutput("err_flag", 64'(err), 64'(exp_err));
      checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      checkOutput("busy_after_done", 64'(busy), 64'd0);
   endtask

   initial begin : main
      int lat;
      int rows;
      int tiles;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_state", 64'({busy, done, err, res_valid, dp_in_id, in_addr, w_addr}), 64'd0);
      reset = 1'b1;

      $display("[TB] basic 2x3 job, ready high");
      beginJob(2, 3, 1);
      checkOutput("busy_after_start", 64'(busy), 64'd1);
      endJob(1'b0, 200);

      $display("[TB] 4x16 job with downstream stalled for 100 cycles");
      beginJob(4, 16, 0);
      repeat (100) @(negedge clk);
      checkOutput("stall_issue_limit", 64'(issue_cnt - job_i0), 64'(RESULT_DEPTH));
      checkOutput("stall_res_valid", 64'(res_valid), 64'd1);
      checkOutput("stall_no_err", 64'(err), 64'd0);
      ready_mode = 1;
      endJob(1'b0, 600);

      $display("[TB] zero-tile job");
      beginJob(5, 0, 1);
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (done && lat == 0) lat = k;
      end
      checkOutput("zero_done_latency", 64'(lat), 64'd2);
      checkOutput("zero_issue_count", 64'(issue_cnt - job_i0), 64'd0);
      checkOutput("zero_res_valid", 64'(valid_cnt - job_v0), 64'd0);
      checkOutput("zero_done_pulses", 64'(done_cnt - job_d0), 64'd1);

      $display("[TB] corrupted tag sets sticky err");
      corrupt_tag = 1'b1;
      beginJob(2, 3, 1);
      endJob(1'b1, 200);
      corrupt_tag = 1'b0;
      beginJob(2, 3, 1);
      checkOutput("err_cleared_on_start", 64'(err), 64'd0);
      endJob(1'b0, 200);

      $display("[TB] start and cfg changes while busy are ignored");
      beginJob(3, 4, 1);
      repeat (4) @(negedge clk);
      checkOutput("busy_mid_job", 64'(busy), 64'd1);
      applyStimulus(7, 9);
      endJob(1'b0, 300);

      $display("[TB] random jobs with random downstream ready");
      for (int j = 0; j < 6; j++) begin
         rows  = $urandom_range(1, 5);
         tiles = $urandom_range(1, 12);
         beginJob(rows, tiles, 2);
         endJob(1'b0, 4 * rows * tiles + 200);
      end

      $display("[TB] asynchronous reset in the middle of a 50x200 job");
      beginJob(50, 200, 1);
      repeat (40) @(posedge clk);
      #3;
      checkOutput("busy_before_reset", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      checkOutput("reset_async", 64'({busy, done, err, res_valid, dp_in_id, in_addr, w_addr}), 64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      beginJob(1, 1, 1);
      endJob(1'b0, 100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
